serpent_key_sched: RTL and testbench

//   Serpent key schedule engine: expands a 256-bit user key into the 33 128-bit

---
 rtl/serpent_key_sched.sv | 178 +++++++++++++++++
 tb/tb_serpent_key_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serpent_key_sched.sv
// Serpent key schedule: expands a 256-bit user key into 33 round subkeys, one write per cycle.
// Optional in-block key padding (i_key_len port) is enabled by defining SERPENT_KEY_PAD_EN.
module serpent_key_sched #(
  parameter int unsigned NUM_KEYS = 33,
  parameter int unsigned ADDR_W   = 6,
  parameter logic [31:0] PHI      = 32'h9e3779b9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [255:0]      i_key,
`ifdef SERPENT_KEY_PAD_EN
  input  logic [1:0]        i_key_len,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [127:0]      o_wr_key
);

  typedef enum logic [1:0] {StIdle, StGen, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastK = ADDR_W'(NUM_KEYS - 1);

  state_e                   state_q, state_d;
  logic [7:0][31:0]         win_q, win_d;
  logic [ADDR_W-1:0]        k_q, k_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [127:0]             wr_key_q, wr_key_d;

  logic [3:0][31:0]         w_new;
  logic [127:0]             subkey;
  logic [255:0]             key_in;

  // Tables listed in natural order: entry 0 occupies the top nibble.
  function automatic logic [3:0] sbox(input logic [2:0] sel, input logic [3:0] x);
    logic [63:0] tbl;
    logic [3:0]  idx;
    unique case (sel)
      3'd0: tbl = 64'h38F1A65BED42709C;
      3'd1: tbl = 64'hFC27905A1BE86D34;
      3'd2: tbl = 64'h86793CAFD1E40B52;
      3'd3: tbl = 64'h0FB8C963D124A75E;
      3'd4: tbl = 64'h1F83C0B6254A9E7D;
      3'd5: tbl = 64'hF52B4A9C03E8D671;
      3'd6: tbl = 64'h72C5846BE91FD3A0;
      3'd7: tbl = 64'h1DF0E82B74CA9356;
    endcase
    idx = 4'd15 - x;
    return tbl[{idx, 2'b00} +: 4];
  endfunction

`ifdef SERPENT_KEY_PAD_EN
  // Short keys get a single 1 just above the key, zeros beyond.
  function automatic logic [255:0] pad_key(input logic [255:0] key, input logic [1:0] len);
    logic [255:0] p;
    p = key;
    case (len)
      2'd0: begin
        p[255:128] = '0;
        p[128]     = 1'b1;
      end
      2'd1: begin
        p[255:192] = '0;
        p[192]     = 1'b1;
      end
      default: ;
    endcase
    return p;
  endfunction

  assign key_in = pad_key(i_key, i_key_len);
`else
  assign key_in = i_key;
`endif

  always_comb begin : prekey_gen
    logic [31:0] ext [12];
    logic [31:0] base;
    logic [31:0] t;
    logic [3:0]  nib;
    logic [3:0]  sout;
    logic [2:0]  sel;
    base = {{(30 - ADDR_W){1'b0}}, k_q, 2'b00};
    for (int i = 0; i < 8; i++) begin
      ext[i] = win_q[i];
    end
    // ext[8..11] are w[4k..4k+3]; later words chain on earlier ones in the same cycle.
    for (int j = 0; j < 4; j++) begin
      t = ext[j] ^ ext[j+3] ^ ext[j+5] ^ ext[j+7] ^ PHI ^ (base + 32'(j));
      ext[j+8] = (t << 11) | (t >> 21);
    end
    for (int j = 0; j < 4; j++) begin
      w_new[j] = ext[j+8];
    end
    sel    = 3'd3 - k_q[2:0];
    subkey = '0;
    for (int b = 0; b < 32; b++) begin
      nib            = {ext[11][b], ext[10][b], ext[9][b], ext[8][b]};
      sout           = sbox(sel, nib);
      subkey[b]      = sout[0];
      subkey[32+b]   = sout[1];
      subkey[64+b]   = sout[2];
      subkey[96+b]   = sout[3];
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    k_d       = k_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_key_d  = wr_key_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          win_d   = key_in;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = StGen;
        end
      end
      StGen: begin
        wr_en_d   = 1'b1;
        wr_addr_d = k_q;
        wr_key_d  = subkey;
        win_d     = {w_new, win_q[7:4]};
        if (k_q == LastK) begin
          state_d = StDone;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      win_q     <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_key_q  <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_key_q  <= wr_key_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_key  = wr_key_q;

endmodule

// File: tb/tb_serpent_key_sched.sv
// Self-checking bench for serpent_key_sched: table of keys vs. a reference key-schedule model,
// plus start-while-busy, back-to-back and mid-run reset sequences.
module tb_serpent_key_sched;

  localparam int NK = 33;

  typedef logic [NK-1:0][127:0] ks_t;
  typedef struct {
    logic [255:0] key;
    logic [1:0]   len;
    ks_t          exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [255:0] key = '0;
  logic [1:0]   key_len = 2'd2;
  logic         busy, done, wr_en;
  logic [5:0]   wr_addr;
  logic [127:0] wr_key;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of what the held address/key outputs should currently show.
  logic [5:0]   exp_addr = '0;
  logic [127:0] exp_key  = '0;

  int sb [8][16] = '{
    '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
    '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
    '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
    '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
    '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
    '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
    '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
    '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
  };

  serpent_key_sched dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_key     (key),
`ifdef SERPENT_KEY_PAD_EN
    .i_key_len (key_len),
`endif
    .o_busy    (busy),
    .o_done    (done),
    .o_wr_en   (wr_en),
    .o_wr_addr (wr_addr),
    .o_wr_key  (wr_key)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic ks_t expand(input logic [255:0] k);
    logic [31:0] w [140];
    logic [31:0] t;
    logic [3:0]  nib;
    int          s;
    int          o;
    ks_t         r;
    for (int i = 0; i < 8; i++) w[i] = k[32*i +: 32];
    for (int i = 0; i < 132; i++) begin
      t = w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ 32'h9e3779b9 ^ 32'(i);
      w[i+8] = {t[20:0], t[31:21]};
    end
    for (int n = 0; n < NK; n++) begin
      s = (43 - n) % 8;
      for (int b = 0; b < 32; b++) begin
        nib = {w[8+4*n+3][b], w[8+4*n+2][b], w[8+4*n+1][b], w[8+4*n][b]};
        o = sb[s][nib];
        r[n][b]      = o[0];
        r[n][32+b]   = o[1];
        r[n][64+b]   = o[2];
        r[n][96+b]   = o[3];
      end
    end
    return r;
  endfunction

`ifdef SERPENT_KEY_PAD_EN
  function automatic logic [255:0] pad(input logic [255:0] k, input logic [1:0] len);
    int nbits;
    logic [255:0] r;
    nbits = (len == 2'd0) ? 128 : (len == 2'd1) ? 192 : 256;
    r = '0;
    for (int i = 0; i < nbits; i++) r[i] = k[i];
    if (nbits < 256) r[nbits] = 1'b1;
    return r;
  endfunction
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int cyc, input logic e_busy, input logic e_done,
                       input logic e_en);
    n_checks++;
    if (busy !== e_busy || done !== e_done || wr_en !== e_en || wr_addr !== exp_addr ||
        wr_key !== exp_key) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got busy=%b done=%b en=%b addr=%0d key=%h want busy=%b done=%b en=%b addr=%0d key=%h",
               name, cyc, busy, done, wr_en, wr_addr, wr_key,
               e_busy, e_done, e_en, exp_addr, exp_key);
    end
  endtask

  // Full run starting at the next edge. With hold_start, i_start stays high (with a dip and a
  // re-pulse) through GEN and DONE while i_key is scrambled; neither may disturb the run.
  task automatic run_seq(input vec_t v, input string name, input bit hold_start);
    key   = v.key;
    key_len = v.len;
    start = 1'b1;
    tick();
    check(name, 0, 1'b1, 1'b0, 1'b0);
    if (hold_start) key = ~v.key;
    else start = 1'b0;
    for (int c = 1; c <= NK; c++) begin
      if (hold_start) start = (c != 9);
      tick();
      exp_addr = 6'(c - 1);
      exp_key  = v.exp[c-1];
      check(name, c, 1'b1, 1'b0, 1'b1);
    end
    tick();
    start = 1'b0;
    check(name, NK + 1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      check(name, c, 1'b0, 1'b0, 1'b0);
    end
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0].key = '0;
    vecs[1].key = 256'h00112233445566778899aabbccddeeff_0123456789abcdeffedcba9876543210;
    vecs[2].key = '1;
    vecs[3].key = '0;
    vecs[3].key[255] = 1'b1;
    vecs[3].key[0]   = 1'b1;
    vecs[4].key = 256'hdeadbeef_cafef00d_13579bdf_2468ace0_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    for (int i = 0; i < 5; i++) begin
      vecs[i].len = 2'd2;
      vecs[i].exp = expand(vecs[i].key);
    end

    // Reset state.
    #2 rst = 1'b1;
    #1;
    check("reset", 0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    idle_cycles("idle_after_reset", 2);

    // Table: each key runs back-to-back, next start on the cycle right after o_done.
    for (int i = 0; i < 5; i++) begin
      run_seq(vecs[i], $sformatf("vec%0d", i), 1'b0);
    end
    idle_cycles("idle_hold", 2);

    // Start held/re-pulsed while busy and in DONE, then a back-to-back different key.
    run_seq(vecs[1], "start_held", 1'b1);
    run_seq(vecs[2], "b2b_after_held", 1'b0);

    // Asynchronous reset in the middle of cycle 17 aborts the run.
    key   = vecs[4].key;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      exp_addr = 6'(c - 1);
      exp_key  = vecs[4].exp[c-1];
      check("pre_abort", c, 1'b1, 1'b0, 1'b1);
    end
    #2 rst = 1'b1;
    #1;
    exp_addr = '0;
    exp_key  = '0;
    check("abort_async", 17, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    idle_cycles("after_abort", 20);
    run_seq(vecs[3], "post_abort", 1'b0);

`ifdef SERPENT_KEY_PAD_EN
    begin
      vec_t pv;
      pv.key = 256'h1;
      pv.len = 2'd0;
      pv.exp = expand(pad(pv.key, pv.len));
      run_seq(pv, "pad128", 1'b0);
      pv.key = '1;
      pv.len = 2'd0;
      pv.exp = expand(pad(pv.key, pv.len));
      run_seq(pv, "pad128_ones", 1'b0);
      pv.key = vecs[4].key;
      pv.len = 2'd1;
      pv.exp = expand(pad(pv.key, pv.len));
      run_seq(pv, "pad192", 1'b0);
      pv.len = 2'd3;
      pv.exp = vecs[4].exp;
      run_seq(pv, "len3_as_256", 1'b0);
    end
`endif

    idle_cycles("final_idle", 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
